// File: rtl/alu_seq_ctrl_pkg.sv
// rtl/alu_seq_ctrl_pkg.sv - shared state encodings and ALU opcodes for the operator sequencer
package alu_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_B = 2'd1,
    S_EXEC   = 2'd2,
    S_SHOW   = 2'd3
  } seq_state_e;

  // Opcode map shared with the calculate ALU
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_e;

  localparam int unsigned OPERAND_W = 8;
  localparam int unsigned RESULT_W  = 32;

  function automatic logic [RESULT_W-1:0] zext_operand(input logic [OPERAND_W-1:0] v);
    return {{(RESULT_W - OPERAND_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// rtl/alu_seq_ctrl_btn_debounce.sv - pushbutton synchroniser, debouncer and press-pulse generator
module btn_debounce
  import alu_seq_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W = $clog2(32'(DEBOUNCE_CYCLES) + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter only advances while the synchronised input disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          pulse_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - operator sequencer: collects operands, drives the ALU, captures its result
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter int unsigned EXEC_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_clr,
  input  logic [7:0]  sw_num,
  input  logic [2:0]  sw_op,
  input  logic [31:0] alu_result,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic [31:0] disp_value,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_code
);

  localparam int EXEC_W = $clog2(EXEC_CYCLES + 32'd1);
  localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(EXEC_CYCLES - 32'd1);

  logic next_p;
  logic clr_p;
  logic next_level_unused;
  logic clr_level_unused;

  seq_state_e         state_q;
  logic [EXEC_W-1:0]  exec_cnt_q;
  logic [7:0]         alu_a_q;
  logic [7:0]         alu_b_q;
  logic [2:0]         alu_op_q;
  logic [31:0]        disp_q;
  logic               busy_q;
  logic               done_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_next),
    .btn_level(next_level_unused),
    .btn_pulse(next_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_clr (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_clr),
    .btn_level(clr_level_unused),
    .btn_pulse(clr_p)
  );

  // Clear is checked ahead of the state case so it overrides a same-cycle next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      exec_cnt_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      disp_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clr_p) begin
        state_q    <= S_IDLE;
        exec_cnt_q <= '0;
        alu_a_q    <= '0;
        alu_b_q    <= '0;
        alu_op_q   <= '0;
        disp_q     <= '0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_SHOW: begin
            if (next_p) begin
              alu_a_q <= sw_num;
              disp_q  <= zext_operand(sw_num);
              state_q <= S_WAIT_B;
            end
          end
          S_WAIT_B: begin
            if (next_p) begin
              alu_b_q    <= sw_num;
              alu_op_q   <= sw_op;
              busy_q     <= 1'b1;
              exec_cnt_q <= '0;
              state_q    <= S_EXEC;
            end
          end
          S_EXEC: begin
            // Operands stay frozen here; a next press is simply not looked at.
            if (exec_cnt_q == EXEC_LAST) begin
              disp_q     <= alu_result;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              exec_cnt_q <= '0;
              state_q    <= S_SHOW;
            end else begin
              exec_cnt_q <= exec_cnt_q + EXEC_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign disp_value = disp_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_code = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed bench for alu_seq_ctrl (short and long exec windows side by side)
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next;
  logic        btn_clr;
  logic [7:0]  sw_num;
  logic [2:0]  sw_op;
  logic [31:0] alu_result;

  logic [7:0]  a_o, b_o, a2_o, b2_o;
  logic [2:0]  op_o, op2_o;
  logic [31:0] disp_o, disp2_o;
  logic        busy_o, done_o, busy2_o, done2_o;
  logic [1:0]  sc_o, sc2_o;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DEBOUNCE_CYCLES(20'd4), .EXEC_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_clr(btn_clr),
    .sw_num(sw_num), .sw_op(sw_op), .alu_result(alu_result),
    .alu_a(a_o), .alu_b(b_o), .alu_op(op_o), .disp_value(disp_o),
    .busy(busy_o), .done(done_o), .state_code(sc_o)
  );

  // Long exec window so a second press and a clear can land inside S_EXEC.
  alu_seq_ctrl #(.DEBOUNCE_CYCLES(20'd4), .EXEC_CYCLES(32)) dut_long (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_clr(btn_clr),
    .sw_num(sw_num), .sw_op(sw_op), .alu_result(alu_result),
    .alu_a(a2_o), .alu_b(b2_o), .alu_op(op2_o), .disp_value(disp2_o),
    .busy(busy2_o), .done(done2_o), .state_code(sc2_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int k, busy_n, done_n, done_k, trans_n, busy2_n, done2_n, trans2_n;
  logic [1:0] prev_sc, prev_sc2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic watch_reset();
    k = 0; busy_n = 0; done_n = 0; done_k = 0; trans_n = 0;
    busy2_n = 0; done2_n = 0; trans2_n = 0;
    prev_sc = sc_o; prev_sc2 = sc2_o;
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
    if (busy_o) busy_n++;
    if (done_o) begin done_n++; done_k = k; end
    if (sc_o != prev_sc) trans_n++;
    prev_sc = sc_o;
    if (busy2_o) busy2_n++;
    if (done2_o) done2_n++;
    if (sc2_o != prev_sc2) trans2_n++;
    prev_sc2 = sc2_o;
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    repeat (10) tick();
    btn_next = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    rst = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
    sw_num = 8'h00; sw_op = 3'd0; alu_result = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_alu_a", 32'(a_o), 32'h0);
    check_eq("rst_alu_b", 32'(b_o), 32'h0);
    check_eq("rst_alu_op", 32'(op_o), 32'h0);
    check_eq("rst_disp", disp_o, 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);
    check_eq("rst_done", 32'(done_o), 32'h0);
    check_eq("rst_state", 32'(sc_o), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_state", 32'(sc_o), 32'h0);

    // Bounces alone: no accepted edge
    sw_num = 8'h12;
    watch_reset();
    btn_next = 1'b1; tick(); btn_next = 1'b0; tick();
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    repeat (10) tick();
    check_eq("bounce_only_trans", 32'(trans_n), 32'd0);
    check_eq("bounce_only_state", 32'(sc_o), 32'd0);

    // Bounce then hold: exactly one transition, operand A captured
    watch_reset();
    btn_next = 1'b1; tick(); btn_next = 1'b0; tick();
    btn_next = 1'b1;
    repeat (10) tick();
    check_eq("bounce_hold_trans", 32'(trans_n), 32'd1);
    check_eq("a_state", 32'(sc_o), 32'd1);
    check_eq("a_alu_a", 32'(a_o), 32'h12);
    check_eq("a_disp", disp_o, 32'h12);
    btn_next = 1'b0;
    repeat (10) tick();

    // Operand B + exec; second press lands in SHOW (short) and EXEC (long)
    sw_num = 8'h34; sw_op = 3'd0; alu_result = 32'h46;
    watch_reset();
    btn_next = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (k == 6) check_eq("b_pre_state", 32'(sc_o), 32'd1);
      if (k == 7) begin
        check_eq("b_state_exec", 32'(sc_o), 32'd2);
        check_eq("b_busy_rise", 32'(busy_o), 32'd1);
        check_eq("b_alu_b", 32'(b_o), 32'h34);
        check_eq("b_alu_op", 32'(op_o), 32'd0);
      end
      if (k == 10) check_eq("b_disp_before", disp_o, 32'h12);
      if (k == 11) begin
        check_eq("res_disp", disp_o, 32'h46);
        check_eq("res_done", 32'(done_o), 32'd1);
        check_eq("res_busy", 32'(busy_o), 32'd0);
        check_eq("res_state", 32'(sc_o), 32'd3);
      end
      if (k == 12) check_eq("done_one_cycle", 32'(done_o), 32'd0);
      if (k == 21) begin
        check_eq("show_next_state", 32'(sc_o), 32'd1);
        check_eq("show_next_alu_a", 32'(a_o), 32'h05);
        check_eq("show_next_disp", disp_o, 32'h05);
        check_eq("long_drop_state", 32'(sc2_o), 32'd2);
        check_eq("long_drop_alu_a", 32'(a2_o), 32'h12);
        check_eq("long_drop_alu_b", 32'(b2_o), 32'h34);
      end
      if (k == 38) check_eq("long_exec_pre", 32'(sc2_o), 32'd2);
      if (k == 39) begin
        check_eq("long_res_state", 32'(sc2_o), 32'd3);
        check_eq("long_res_done", 32'(done2_o), 32'd1);
        check_eq("long_res_disp", disp2_o, 32'h46);
      end
      if (k == 8) btn_next = 1'b0;
      if (k == 14) begin btn_next = 1'b1; sw_num = 8'h05; end
      if (k == 24) btn_next = 1'b0;
    end
    check_eq("busy_cycles", 32'(busy_n), 32'd4);
    check_eq("done_pulses", 32'(done_n), 32'd1);
    check_eq("done_at", 32'(done_k), 32'd11);
    check_eq("short_trans", 32'(trans_n), 32'd3);
    check_eq("long_busy_cycles", 32'(busy2_n), 32'd32);
    check_eq("long_done_pulses", 32'(done2_n), 32'd1);
    check_eq("long_trans", 32'(trans2_n), 32'd2);

    // Short: WAIT_B -> EXEC -> SHOW; long: SHOW -> WAIT_B
    sw_num = 8'h5a; sw_op = 3'd2; alu_result = 32'h10;
    press_next();
    check_eq("s3_short_disp", disp_o, 32'h10);
    check_eq("s3_short_state", 32'(sc_o), 32'd3);
    check_eq("s3_long_state", 32'(sc2_o), 32'd1);

    // Next plus clear together: long is in EXEC, short in WAIT_B
    watch_reset();
    btn_next = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (k == 20) begin
        check_eq("clr_pre_long_state", 32'(sc2_o), 32'd2);
        check_eq("clr_pre_long_busy", 32'(busy2_o), 32'd1);
        check_eq("clr_pre_long_op", 32'(op2_o), 32'd2);
        check_eq("clr_pre_short_state", 32'(sc_o), 32'd1);
      end
      if (k == 21) begin
        check_eq("clr_long_state", 32'(sc2_o), 32'd0);
        check_eq("clr_long_busy", 32'(busy2_o), 32'd0);
        check_eq("clr_long_alu_a", 32'(a2_o), 32'h0);
        check_eq("clr_long_alu_b", 32'(b2_o), 32'h0);
        check_eq("clr_long_alu_op", 32'(op2_o), 32'h0);
        check_eq("clr_long_disp", disp2_o, 32'h0);
        check_eq("clr_short_state", 32'(sc_o), 32'd0);
        check_eq("clr_short_alu_a", 32'(a_o), 32'h0);
        check_eq("clr_short_disp", disp_o, 32'h0);
      end
      if (k == 8) btn_next = 1'b0;
      if (k == 14) begin btn_next = 1'b1; btn_clr = 1'b1; end
      if (k == 24) begin btn_next = 1'b0; btn_clr = 1'b0; end
    end
    check_eq("clr_long_no_done", 32'(done2_n), 32'd0);

    // Asynchronous reset in the middle of S_EXEC
    sw_num = 8'h77;
    press_next();
    sw_num = 8'h88; alu_result = 32'hdeadbeef;
    btn_next = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("arst_pre_busy", 32'(busy_o), 32'd1);
    check_eq("arst_pre_disp", disp_o, 32'h77);
    #1 rst = 1'b0;
    #2;
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    check_eq("arst_state", 32'(sc_o), 32'd0);
    check_eq("arst_alu_a", 32'(a_o), 32'h0);
    check_eq("arst_alu_b", 32'(b_o), 32'h0);
    check_eq("arst_alu_op", 32'(op_o), 32'h0);
    check_eq("arst_disp", disp_o, 32'h0);
    check_eq("arst_long_state", 32'(sc2_o), 32'd0);
    btn_next = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("arst_after_state", 32'(sc_o), 32'd0);
    check_eq("arst_after_done", 32'(done_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
